// File: rtl/hex_segment_reader_pkg.sv
// Shared types for the seven-segment readback path.
// Segment patterns are active-high, bit order g..a.
package hex_segment_reader_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  localparam seg_t BLANK = 7'h00;
  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_A = 7'h77;
  localparam seg_t SEG_B = 7'h7C;
  localparam seg_t SEG_C = 7'h39;
  localparam seg_t SEG_D = 7'h5E;
  localparam seg_t SEG_E = 7'h79;
  localparam seg_t SEG_F = 7'h71;

endpackage

// File: rtl/hex_segment_reader_if.sv
// Segment input plus decoded-digit valid/ready bundle.
// master = reader side, slave = bus driver / consumer side.
interface hex_segment_reader_if;
  import hex_segment_reader_pkg::*;

  seg_t       seg_n;
  logic [3:0] digit;
  logic       valid;
  logic       ready;
  logic       err;
  logic [7:0] err_count;

  modport master (
    input  seg_n, ready,
    output digit, valid, err, err_count
  );

  modport slave (
    output seg_n, ready,
    input  digit, valid, err, err_count
  );
endinterface

// File: rtl/hex_segment_reader_seg_pattern_decode.sv
// Combinational segment pattern to hex digit classifier.
// Shared with the display-driver side for self-check.
module seg_pattern_decode
  import hex_segment_reader_pkg::*;
(
  input  seg_t       pat,
  output logic       is_digit,
  output logic       is_blank,
  output logic [3:0] value
);

  always_comb begin
    is_digit = 1'b1;
    is_blank = 1'b0;
    value    = 4'h0;
    unique case (pat)
      SEG_0: value = 4'h0;
      SEG_1: value = 4'h1;
      SEG_2: value = 4'h2;
      SEG_3: value = 4'h3;
      SEG_4: value = 4'h4;
      SEG_5: value = 4'h5;
      SEG_6: value = 4'h6;
      SEG_7: value = 4'h7;
      SEG_8: value = 4'h8;
      SEG_9: value = 4'h9;
      SEG_A: value = 4'hA;
      SEG_B: value = 4'hB;
      SEG_C: value = 4'hC;
      SEG_D: value = 4'hD;
      SEG_E: value = 4'hE;
      SEG_F: value = 4'hF;
      BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/hex_segment_reader.sv
// Stable-pattern seven-segment reader with valid/ready output.
// HEX_SEGMENT_READER_ERRCNT_EN builds the saturating err_count.
module hex_segment_reader
  import hex_segment_reader_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  hex_segment_reader_if.master bus
);

  localparam logic [7:0] LIM = 8'(STABLE_CYCLES);

  seg_t       sync1_n;
  seg_t       sync2_n;
  seg_t       s;
  seg_t       last;
  seg_t       cand;
  logic [7:0] cnt;
  state_t     state;
  logic [3:0] digit_q;
  logic       valid_q;
  logic       err_q;
  logic       is_digit;
  logic       is_blank;
  logic [3:0] value;

  // Resetting to all-ones keeps the synced view blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_n <= '1;
      sync2_n <= '1;
    end else begin
      sync1_n <= bus.seg_n;
      sync2_n <= sync1_n;
    end
  end

  assign s = ~sync2_n;

  seg_pattern_decode u_dec (
    .pat      (cand),
    .is_digit (is_digit),
    .is_blank (is_blank),
    .value    (value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= BLANK;
      cand    <= BLANK;
      cnt     <= '0;
      digit_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s != last) begin
            cand  <= s;
            cnt   <= 8'd1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (s == last) begin
            state <= IDLE;
          end else if (s != cand) begin
            cand <= s;
            cnt  <= 8'd1;
          end else if (cnt == LIM) begin
            last  <= cand;
            state <= IDLE;
            if (is_digit) begin
              digit_q <= value;
              valid_q <= 1'b1;
              state   <= HOLD;
            end else if (!is_blank) begin
              err_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (bus.ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.digit = digit_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;

`ifdef HEX_SEGMENT_READER_ERRCNT_EN
  logic [7:0] ecnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt <= '0;
    end else if (err_q && ecnt != 8'hFF) begin
      ecnt <= ecnt + 8'd1;
    end
  end

  assign bus.err_count = ecnt;
`else
  assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_hex_segment_reader.sv
// Self-checking bench for hex_segment_reader.
// Vector table plus scoreboard of expected tokens.
module tb_hex_segment_reader;

  localparam int SC  = 4;
  localparam int LAT = 2 + SC + 1;

  typedef struct {
    logic [6:0] pat;
    int         tok;
    logic [3:0] dig;
    int         err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hex_segment_reader_if bus ();

  hex_segment_reader #(.STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [6:0] pats [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int         checks = 0;
  int         errors = 0;
  int         tok_seen = 0;
  int         err_seen = 0;
  int         exp_errcnt = 0;
  logic [3:0] exp_q [$];
  vec_t       vecs [$];
  logic       pv = 1'b0;
  logic [3:0] pd = 4'h0;
  logic [3:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (bus.err) err_seen++;
      if (bus.valid && pv) begin
        checks++;
        if (bus.digit !== pd) begin
          errors++;
          $display("FAIL digit_stable got=%h want=%h", bus.digit, pd);
        end
      end
      if (bus.valid && bus.ready) begin
        tok_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_token got=%h want=none", bus.digit);
        end else begin
          e = exp_q.pop_front();
          if (bus.digit !== e) begin
            errors++;
            $display("FAIL token_value got=%h want=%h", bus.digit, e);
          end
        end
      end
      pv = bus.valid && !bus.ready;
      pd = bus.digit;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] pat);
    bus.seg_n = ~pat;
  endtask

  task automatic wait_tok(input int target, input int budget, input string name);
    int n = 0;
    while (tok_seen < target && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, tok_seen, target);
  endtask

  task automatic measure(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid) begin
        lat = k;
        break;
      end
    end
  endtask

  function automatic int exp_cnt();
`ifdef HEX_SEGMENT_READER_ERRCNT_EN
    return exp_errcnt;
`else
    return 0;
`endif
  endfunction

  function automatic int outs();
    return {bus.digit, bus.valid, bus.err, bus.err_count};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_errcnt = 0;
    chk("reset_outputs", outs(), 0);
  endtask

  initial begin
    int t0;
    int e0;
    int lat;

    for (int i = 0; i < 16; i++) begin
      vecs.push_back('{pats[i], 1, 4'(i), 0});
      vecs.push_back('{7'h00, 0, 4'h0, 0});
    end
    vecs.push_back('{7'h01, 0, 4'h0, 1});
    vecs.push_back('{7'h00, 0, 4'h0, 0});
    vecs.push_back('{7'h06, 1, 4'h1, 0});
    vecs.push_back('{7'h06, 0, 4'h0, 0});
    vecs.push_back('{7'h5B, 1, 4'h2, 0});
    vecs.push_back('{7'h7E, 0, 4'h0, 1});
    vecs.push_back('{7'h00, 0, 4'h0, 0});

    bus.seg_n = 7'h7F;
    bus.ready = 1'b1;
    tick(3);
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_outputs", outs(), 0);

    // basic decode with latency
    t0 = tok_seen;
    exp_q.push_back(4'h1);
    drive(7'h06);
    measure(lat);
    chk("basic_latency", lat, LAT);
    tick(20);
    chk("basic_once", tok_seen - t0, 1);

    drive(7'h00);
    tick(10);

    // glitch shorter than the stability window
    t0 = tok_seen;
    e0 = err_seen;
    drive(7'h5B);
    tick(3);
    drive(7'h00);
    tick(12);
    chk("glitch_tok", tok_seen - t0, 0);
    chk("glitch_err", err_seen - e0, 0);

    foreach (vecs[i]) begin
      t0 = tok_seen;
      e0 = err_seen;
      if (vecs[i].tok != 0) exp_q.push_back(vecs[i].dig);
      exp_errcnt += vecs[i].err;
      drive(vecs[i].pat);
      tick(10);
      chk($sformatf("vec%0d_tok", i), tok_seen - t0, vecs[i].tok);
      chk($sformatf("vec%0d_err", i), err_seen - e0, vecs[i].err);
    end
    chk("err_count", int'(bus.err_count), exp_cnt());

    // back-pressure across an input change
    bus.ready = 1'b0;
    t0 = tok_seen;
    exp_q.push_back(4'h3);
    exp_q.push_back(4'h4);
    drive(7'h4F);
    tick(10);
    chk("bp_valid", int'(bus.valid), 1);
    chk("bp_digit", int'(bus.digit), 3);
    drive(7'h66);
    tick(10);
    chk("bp_hold_valid", int'(bus.valid), 1);
    chk("bp_hold_digit", int'(bus.digit), 3);
    bus.ready = 1'b1;
    wait_tok(t0 + 1, 5, "bp_first");
    wait_tok(t0 + 2, 2 + SC + 4, "bp_second");
    tick(10);
    chk("bp_no_dup", tok_seen - t0, 2);

    drive(7'h00);
    tick(10);

    // reset in the middle of SETTLE
    drive(7'h7D);
    tick(4);
    do_reset();
    tick(2);
    t0 = tok_seen;
    exp_q.push_back(4'h6);
    rst_n = 1'b1;
    measure(lat);
    chk("rst_settle_lat", lat, LAT);
    tick(10);
    chk("rst_settle_tok", tok_seen - t0, 1);

    // reset while a token is held
    bus.ready = 1'b0;
    drive(7'h6F);
    tick(10);
    chk("hold_valid", int'(bus.valid), 1);
    do_reset();
    tick(2);
    bus.ready = 1'b1;
    t0 = tok_seen;
    exp_q.push_back(4'h9);
    rst_n = 1'b1;
    measure(lat);
    chk("rst_hold_lat", lat, LAT);
    tick(10);
    chk("rst_hold_tok", tok_seen - t0, 1);

    // error counter saturation
    t0 = tok_seen;
    e0 = err_seen;
    for (int i = 0; i < 260; i++) begin
      drive(7'h01);
      tick(9);
      drive(7'h00);
      tick(9);
      if (exp_errcnt < 255) exp_errcnt++;
    end
    chk("sat_err_pulses", err_seen - e0, 260);
    chk("sat_tok", tok_seen - t0, 0);
    chk("sat_err_count", int'(bus.err_count), exp_cnt());

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
